chacha_block_gen: RTL and testbench

Parametrised ChaCha block-function engine: accepts a 16-word input state over a valid/ready handshake, runs a configurable number of rounds, adds the original state back, and presents the 16-word keystream block until it is accepted. Round count and quarter-round parallelism are set at elaboration. A continuation mode regenerates the next block with the block counter incremented, without a new input transfer. The block sits between key/nonce setup logic and the XOR stage of the stream-cipher datapath.

---
 rtl/chacha_pkg.sv | 35 +++
 rtl/chacha_block_gen_qr.sv | 32 +++
 rtl/chacha_block_gen.sv | 140 ++++++++++++++
 tb/tb_chacha_block_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// Shared types, constants and helpers for the ChaCha block-function engine.
package chacha_pkg;

  typedef logic [31:0] word_t;
  typedef word_t state_t [16];

  localparam word_t SIGMA0 = 32'h6170_7865;
  localparam word_t SIGMA1 = 32'h3320_646e;
  localparam word_t SIGMA2 = 32'h7962_2d32;
  localparam word_t SIGMA3 = 32'h6b20_6574;

  // Quarter-round issue order within a double round: four columns, then four diagonals.
  localparam int unsigned QR_IDX [8][4] = '{
    '{0, 4,  8, 12},
    '{1, 5,  9, 13},
    '{2, 6, 10, 14},
    '{3, 7, 11, 15},
    '{0, 5, 10, 15},
    '{1, 6, 11, 12},
    '{2, 7,  8, 13},
    '{3, 4,  9, 14}
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_ADD   = 2'd2,
    ST_OUT   = 2'd3
  } fsm_t;

  function automatic word_t rotl(input word_t v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

endpackage

// File: rtl/chacha_block_gen_qr.sv
// Single ChaCha quarter-round, purely combinational.
module chacha_qr
  import chacha_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t c,
  input  word_t d,
  output word_t na,
  output word_t nb,
  output word_t nc,
  output word_t nd
);

  word_t a1, b1, c1, d1;
  word_t a2, b2, c2, d2;

  assign a1 = a + b;
  assign d1 = rotl(d ^ a1, 16);
  assign c1 = c + d1;
  assign b1 = rotl(b ^ c1, 12);
  assign a2 = a1 + b1;
  assign d2 = rotl(d1 ^ a2, 8);
  assign c2 = c1 + d2;
  assign b2 = rotl(b1 ^ c2, 7);

  assign na = a2;
  assign nb = b2;
  assign nc = c2;
  assign nd = d2;

endmodule

// File: rtl/chacha_block_gen.sv
// ChaCha block function: rounds over a latched state, feed-forward add, held
// output block, optional counter-incremented continuation.
module chacha_block_gen
  import chacha_pkg::*;
#(
  parameter int unsigned ROUNDS       = 20,
  parameter int unsigned QR_PER_CYCLE = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  output logic   in_ready,
  input  state_t state_in,
  input  logic   cont,
  output logic   out_valid,
  input  logic   out_ready,
  output state_t state_out
);

  localparam int unsigned STEPS = 4 * ROUNDS / QR_PER_CYCLE;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (ROUNDS < 2 || (ROUNDS % 2) != 0) begin : g_bad_rounds
    $error("chacha_block_gen: ROUNDS must be even and >= 2");
  end
  if (!(QR_PER_CYCLE == 1 || QR_PER_CYCLE == 2 || QR_PER_CYCLE == 4)) begin : g_bad_qpc
    $error("chacha_block_gen: QR_PER_CYCLE must be 1, 2 or 4");
  end

  fsm_t          state, state_nx;
  state_t        x, s, x_rnd;
  logic [CW-1:0] step;
  logic          last_step;
  logic [2:0]    grp_base;
  word_t         s12_inc;

  logic [3:0] qi   [QR_PER_CYCLE][4];
  word_t      qin  [QR_PER_CYCLE][4];
  word_t      qout [QR_PER_CYCLE][4];

  assign last_step = (step == CW'(STEPS - 1));
  // Group position within the double round; wraps every 8 quarter-rounds.
  assign grp_base  = 3'(32'(step) * QR_PER_CYCLE);
  assign s12_inc   = s[12] + 32'd1;

  always_comb begin
    for (int j = 0; j < int'(QR_PER_CYCLE); j++) begin
      for (int k = 0; k < 4; k++) begin
        qi[j][k]  = 4'(QR_IDX[grp_base + 3'(j)][k]);
        qin[j][k] = x[qi[j][k]];
      end
    end
  end

  for (genvar j = 0; j < int'(QR_PER_CYCLE); j++) begin : g_qr
    chacha_qr u_qr (
      .a  (qin[j][0]),
      .b  (qin[j][1]),
      .c  (qin[j][2]),
      .d  (qin[j][3]),
      .na (qout[j][0]),
      .nb (qout[j][1]),
      .nc (qout[j][2]),
      .nd (qout[j][3])
    );
  end

  // Quarter-rounds within a group touch disjoint words, so write-back order is free.
  always_comb begin
    x_rnd = x;
    for (int j = 0; j < int'(QR_PER_CYCLE); j++) begin
      for (int k = 0; k < 4; k++) begin
        x_rnd[qi[j][k]] = qout[j][k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (in_valid)  state_nx = ST_ROUND;
      ST_ROUND: if (last_step) state_nx = ST_ADD;
      ST_ADD:                  state_nx = ST_OUT;
      ST_OUT:   if (out_ready) state_nx = cont ? ST_ROUND : ST_IDLE;
      default:                 state_nx = ST_IDLE;
    endcase
  end

  // Handshake flags mirror the registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_nx == ST_IDLE);
      out_valid <= (state_nx == ST_OUT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '{default: '0};
      s         <= '{default: '0};
      state_out <= '{default: '0};
      step      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x    <= state_in;
            s    <= state_in;
            step <= '0;
          end
        end
        ST_ROUND: begin
          x    <= x_rnd;
          step <= last_step ? '0 : step + CW'(1);
        end
        ST_ADD: begin
          for (int i = 0; i < 16; i++) state_out[i] <= x[i] + s[i];
        end
        ST_OUT: begin
          if (out_ready && cont) begin
            s[12] <= s12_inc;
            x     <= s;
            x[12] <= s12_inc;
            step  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_block_gen.sv
// Scoreboard bench for chacha_block_gen: RFC vectors, latency, backpressure,
// continuation across counter wrap, and reset mid-flight.
module tb_chacha_block_gen;
  import chacha_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   in_valid, in_ready, cont, out_valid, out_ready;
  state_t state_in, state_out;
  logic   in_valid1, in_ready1, out_valid1, out_ready1;
  state_t state_in1, state_out1;
  word_t  qa, qb, qc, qd, qna, qnb, qnc, qnd;

  int unsigned     checks = 0;
  int unsigned     errors = 0;
  int unsigned     n_xfer = 0;
  logic [511:0]    exp_q [$];

  always #5 clk = ~clk;

  chacha_block_gen #(.ROUNDS(20), .QR_PER_CYCLE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .state_in(state_in), .cont(cont), .out_valid(out_valid),
    .out_ready(out_ready), .state_out(state_out)
  );

  chacha_block_gen #(.ROUNDS(20), .QR_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .state_in(state_in1), .cont(1'b0), .out_valid(out_valid1),
    .out_ready(out_ready1), .state_out(state_out1)
  );

  chacha_qr u_qr (
    .a(qa), .b(qb), .c(qc), .d(qd), .na(qna), .nb(qnb), .nc(qnc), .nd(qnd)
  );

  function automatic logic [511:0] pack(input state_t st);
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = st[i];
    return v;
  endfunction

  function automatic word_t rl(input word_t v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Reference ChaCha20 block function, written independently of the RTL.
  function automatic logic [511:0] ref_block(input logic [511:0] in);
    word_t w [16];
    word_t a, b, c, d;
    int ia, ib, ic, id;
    logic [511:0] r;
    for (int i = 0; i < 16; i++) w[i] = in[32*i +: 32];
    for (int dr = 0; dr < 10; dr++) begin
      for (int q = 0; q < 8; q++) begin
        if (q < 4) begin
          ia = q; ib = q + 4; ic = q + 8; id = q + 12;
        end else begin
          ia = q - 4; ib = 4 + (q - 3) % 4; ic = 8 + (q - 2) % 4; id = 12 + (q - 1) % 4;
        end
        a = w[ia]; b = w[ib]; c = w[ic]; d = w[id];
        a = a + b; d = rl(d ^ a, 16);
        c = c + d; b = rl(b ^ c, 12);
        a = a + b; d = rl(d ^ a, 8);
        c = c + d; b = rl(b ^ c, 7);
        w[ia] = a; w[ib] = b; w[ic] = c; w[id] = d;
      end
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i] + in[32*i +: 32];
    return r;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted output block is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_xfer++;
      if (exp_q.size() == 0) check("unexpected_block", 512'(1), 512'(0));
      else                   check("block", pack(state_out), exp_q.pop_front());
    end
  end

  task automatic send(input state_t st);
    int n = 0;
    state_in = st;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 512'(n < 100), 512'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(ref_block(pack(st)));
  endtask

  // Counts edges from the current point to the edge that first samples out_valid=1.
  task automatic wait_out(output int lat, output logic [511:0] blk, output logic saw_rdy);
    logic ov = 1'b0;
    lat = 0;
    saw_rdy = 1'b0;
    blk = '0;
    do begin
      ov = out_valid;
      blk = pack(state_out);
      saw_rdy = saw_rdy | in_ready;
      @(posedge clk); #1;
      lat++;
    end while (!ov && lat < 400);
  endtask

  task automatic check_rfc(input string tag, input logic [511:0] blk);
    check({tag, "_w0"},  512'(blk[31:0]),    512'(32'he4e7f110));
    check({tag, "_w1"},  512'(blk[63:32]),   512'(32'h15593bd1));
    check({tag, "_w15"}, 512'(blk[511:480]), 512'(32'h4e3c50a2));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    state_t rfc, st;
    logic [511:0] blk, snap;
    logic saw, stable;
    int lat, n, x0;

    rfc = '{SIGMA0, SIGMA1, SIGMA2, SIGMA3,
            32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
            32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
            32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};

    rst_n = 1'b0; in_valid = 1'b0; cont = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0;
    state_in = '{default: '0}; state_in1 = '{default: '0};
    qa = 32'h11111111; qb = 32'h01020304; qc = 32'h9b8d6f43; qd = 32'h01234567;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  512'(in_ready),  512'(1));
    check("rst_out_valid", 512'(out_valid), 512'(0));
    check("rst_state_out", pack(state_out), 512'(0));
    check("qr_vector", 512'({qna, qnb, qnc, qnd}),
          512'({32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb}));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // RFC vector, four quarter-rounds per cycle
    out_ready = 1'b1;
    send(rfc);
    wait_out(lat, blk, saw);
    check("latency_qpc4", 512'(lat), 512'(22));
    check_rfc("rfc_qpc4", blk);
    check("ready_after_accept", 512'(in_ready), 512'(1));

    // RFC vector, one quarter-round per cycle
    state_in1 = rfc; in_valid1 = 1'b1; out_ready1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    lat = 0;
    do begin
      stable = out_valid1;
      blk = pack(state_out1);
      @(posedge clk); #1;
      lat++;
    end while (!stable && lat < 400);
    check("latency_qpc1", 512'(lat), 512'(82));
    check("block_qpc1", blk, ref_block(pack(rfc)));
    check_rfc("rfc_qpc1", blk);
    out_ready1 = 1'b0;

    // Backpressure: output held, extra input ignored, one transfer on release
    out_ready = 1'b0;
    st = rfc; st[12] = 32'd7;
    send(st);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    snap = pack(state_out);
    x0 = n_xfer;
    state_in = rfc; in_valid = 1'b1;
    stable = 1'b1; saw = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (pack(state_out) !== snap || !out_valid) stable = 1'b0;
      saw = saw | in_ready;
    end
    check("bp_stable", 512'(stable), 512'(1));
    check("bp_no_ready", 512'(saw), 512'(0));
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle_ready", 512'(in_ready), 512'(1));
    check("bp_valid_drop", 512'(out_valid), 512'(0));
    repeat (5) @(posedge clk);
    #1;
    check("bp_one_xfer", 512'(n_xfer - x0), 512'(1));
    check("bp_still_idle", 512'(in_ready), 512'(1));

    // Continuation across counter wrap; nonce word 13 must carry over untouched
    st = rfc; st[12] = 32'hffffffff;
    cont = 1'b1; out_ready = 1'b1;
    send(st);
    st[12] = 32'h00000000;
    exp_q.push_back(ref_block(pack(st)));
    wait_out(lat, blk, saw);
    cont = 1'b0;
    check("cont_lat1", 512'(lat), 512'(22));
    check("cont_ready1", 512'(saw), 512'(0));
    wait_out(lat, blk, saw);
    check("cont_lat2", 512'(lat), 512'(22));
    check("cont_ready2", 512'(saw), 512'(0));
    check("cont_blk2", blk, ref_block(pack(st)));
    check("cont_idle", 512'(in_ready), 512'(1));

    // Reset mid-round discards the block in flight
    send(rfc);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 512'(out_valid), 512'(0));
    check("mid_rst_in_ready",  512'(in_ready),  512'(1));
    check("mid_rst_state_out", pack(state_out), 512'(0));
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(rfc);
    wait_out(lat, blk, saw);
    check("post_rst_latency", 512'(lat), 512'(22));
    check_rfc("post_rst", blk);

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 512'(exp_q.size()), 512'(0));
    check("out_quiet", 512'(out_valid), 512'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
